isb_cfg_ctrl: RTL



---
 rtl/isb_cfg_pkg.sv | 24 ++
 rtl/isb_cfg_timer.sv | 27 ++
 rtl/isb_cfg_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/isb_cfg_pkg.sv
// Shared types for the ISB configuration sequencer: FSM states, array geometry and the latched command.
package isb_cfg_pkg;

    localparam int ISB_ROWS   = 9;
    localparam int ISB_DATA_W = 8;
    localparam int ISB_ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [ISB_ADDR_W-1:0] col;
        logic [ISB_ADDR_W-1:0] row;
        logic [ISB_DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/isb_cfg_timer.sv
// Loadable down-counter for phase timing; done is high while the count is zero.
// Load wins over decrement; the count parks at zero until reloaded.
module isb_cfg_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/isb_cfg_ctrl.sv
// Sole master of the ISB config wires: one command in flight, write latency SETUP+PULSE+2, read READ+1, error 1.
// cmd_ready drops for the whole access; the response is held until rsp_ready.
module isb_cfg_ctrl
    import isb_cfg_pkg::*;
#(
    parameter int NUM_COLS  = 4,
    parameter int NUM_ROWS  = ISB_ROWS,
    parameter int DATA_W    = ISB_DATA_W,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int READ_CYC  = 2,
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [COL_W-1:0]  cmd_col,
    input  logic [3:0]        cmd_row,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [NUM_ROWS-1:0] row_o,
    output logic [NUM_COLS-1:0] col_write_o,
    output logic [NUM_COLS-1:0] col_read_o,
    output logic [DATA_W-1:0] bit_write_o,
    input  logic [DATA_W-1:0] bit_read_i
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > READ_CYC) ? MAX_SP : READ_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t             state, stateNext;
    cmd_t               cmdQ;
    logic [DATA_W-1:0]  rspData;
    logic               rspErr;
    logic               cmdAccept, addrBad;
    logic               tmrLoad, tmrDone;
    logic [CNT_W-1:0]   tmrLoadVal;
    logic [NUM_ROWS-1:0] rowOh;
    logic [NUM_COLS-1:0] colOh;

    assign cmd_ready = (state == IDLE) && rst_n;
    assign cmdAccept = cmd_valid && cmd_ready;
    assign addrBad   = (int'(cmd_col) >= NUM_COLS) || (int'(cmd_row) >= NUM_ROWS);
    assign rsp_data  = rspData;
    assign rsp_err   = rspErr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmdQ    <= '0;
            rspData <= '0;
            rspErr  <= 1'b0;
        end else begin
            state <= stateNext;
            if (cmdAccept) begin
                cmdQ <= '{wr: cmd_wr, col: ISB_ADDR_W'(cmd_col), row: cmd_row,
                          data: ISB_DATA_W'(cmd_data)};
            end
            if (cmdAccept && addrBad) begin
                rspErr  <= 1'b1;
                rspData <= '0;
            end else if (state == W_HOLD) begin
                rspErr  <= 1'b0;
                rspData <= '0;
            end else if (state == R_ACCESS && tmrDone) begin
                rspErr  <= 1'b0;
                rspData <= bit_read_i;
            end
        end
    end

    always_comb begin
        rowOh = '0;
        for (int i = 0; i < NUM_ROWS; i++) rowOh[i] = (int'(cmdQ.row) == i);
        colOh = '0;
        for (int i = 0; i < NUM_COLS; i++) colOh[i] = (int'(cmdQ.col) == i);
    end

    // Strobes are decoded from state alone, so a reset edge drops them immediately.
    always_comb begin
        stateNext   = state;
        tmrLoadVal  = '0;
        rsp_valid   = 1'b0;
        row_o       = '0;
        col_write_o = '0;
        col_read_o  = '0;
        bit_write_o = '0;
        case (state)
            IDLE: begin
                if (cmdAccept) begin
                    if (addrBad) begin
                        stateNext = RESP;
                    end else if (cmd_wr) begin
                        stateNext  = W_SETUP;
                        tmrLoadVal = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        stateNext  = R_ACCESS;
                        tmrLoadVal = CNT_W'(READ_CYC - 1);
                    end
                end
            end
            W_SETUP: begin
                row_o       = rowOh;
                bit_write_o = DATA_W'(cmdQ.data);
                if (tmrDone) begin
                    stateNext  = W_PULSE;
                    tmrLoadVal = CNT_W'(PULSE_CYC - 1);
                end
            end
            W_PULSE: begin
                row_o       = rowOh;
                bit_write_o = DATA_W'(cmdQ.data);
                col_write_o = colOh;
                if (tmrDone) stateNext = W_HOLD;
            end
            W_HOLD: begin
                row_o       = rowOh;
                bit_write_o = DATA_W'(cmdQ.data);
                stateNext   = RESP;
            end
            R_ACCESS: begin
                row_o      = rowOh;
                col_read_o = colOh;
                if (tmrDone) stateNext = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign tmrLoad = (stateNext != state);

    isb_cfg_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmrLoad),
        .loadVal (tmrLoadVal),
        .done    (tmrDone)
    );

endmodule
